// File: rtl/qerv_mdu_pkg.sv
// Shared constants for the qerv multiply/divide unit: widths, funct3 codes,
// FSM state encodings and the conditional-negate helpers.
package qerv_mdu_pkg;

    localparam int XLEN  = 32;
    localparam int ITER  = 32;
    localparam int CNT_W = 5;

    localparam logic [CNT_W-1:0] CNT_LAST = 5'd31;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;
    localparam logic [1:0] ST_WAIT = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_CALC = ST_CALC,
        S_DONE = ST_DONE,
        S_WAIT = ST_WAIT
    } mdu_state_e;

    function automatic logic [XLEN-1:0] cond_neg(input logic neg, input logic [XLEN-1:0] v);
        if (neg) begin
            return -v;
        end else begin
            return v;
        end
    endfunction

    function automatic logic [2*XLEN-1:0] cond_neg64(input logic neg, input logic [2*XLEN-1:0] v);
        if (neg) begin
            return -v;
        end else begin
            return v;
        end
    endfunction

endpackage

// File: rtl/qerv_mdu_opnd.sv
// Operand sign conditioning: turns rs1/rs2 into unsigned magnitudes and
// derives the result-negation flags for the selected funct3.
module qerv_mdu_opnd
    import qerv_mdu_pkg::*;
(
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    input  logic [2:0]      op_i,
    output logic [XLEN-1:0] mag_a_o,
    output logic [XLEN-1:0] mag_b_o,
    output logic            neg_q_o,
    output logic            neg_r_o
);

    logic a_signed_s;
    logic b_signed_s;
    logic neg_a_s;
    logic neg_b_s;
    logic b_zero_s;

    // Signedness decode and magnitude/flag generation
    always_comb begin
        a_signed_s = 1'b0;
        b_signed_s = 1'b0;
        case (op_i)
            F3_MULH, F3_DIV, F3_REM: begin
                a_signed_s = 1'b1;
                b_signed_s = 1'b1;
            end
            F3_MULHSU: begin
                a_signed_s = 1'b1;
                b_signed_s = 1'b0;
            end
            default: begin
                a_signed_s = 1'b0;
                b_signed_s = 1'b0;
            end
        endcase
        neg_a_s  = a_signed_s & rs1_i[XLEN-1];
        neg_b_s  = b_signed_s & rs2_i[XLEN-1];
        b_zero_s = (rs2_i == {XLEN{1'b0}});
        mag_a_o  = cond_neg(neg_a_s, rs1_i);
        mag_b_o  = cond_neg(neg_b_s, rs2_i);
        // Divide by zero keeps the all-ones quotient unsigned regardless of rs1 sign
        neg_q_o  = (neg_a_s ^ neg_b_s) & ~(op_i[2] & b_zero_s);
        neg_r_o  = neg_a_s;
    end

endmodule

// File: rtl/qerv_mdu.sv
// Iterative RV32M multiply/divide unit: 32-cycle radix-2 shift-add multiply
// and restoring divide behind a valid/ready handshake.
module qerv_mdu
    import qerv_mdu_pkg::*;
#(
    parameter RESET_STRATEGY = "MINI"
) (
    input  logic            clk,
    input  logic            i_rst,
    input  logic            i_mdu_valid,
    input  logic [XLEN-1:0] i_mdu_rs1,
    input  logic [XLEN-1:0] i_mdu_rs2,
    input  logic [2:0]      i_mdu_op,
    output logic [XLEN-1:0] o_mdu_rd,
    output logic            o_mdu_ready
);

    localparam bit RST_RD = (RESET_STRATEGY == "MINI");

    mdu_state_e         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ready_q, ready_d;
    logic [XLEN-1:0]    rd_q, rd_d;
    logic [2:0]         op_q, op_d;
    logic [XLEN-1:0]    mag_a_q, mag_a_d;
    logic [XLEN-1:0]    mag_b_q, mag_b_d;
    logic               neg_quo_q, neg_quo_d;
    logic               neg_rem_q, neg_rem_d;
    logic [2*XLEN-1:0]  acc_q, acc_d;
    logic [XLEN:0]      rem_q, rem_d;
    logic [XLEN-1:0]    quo_q, quo_d;

    logic [XLEN-1:0]    opnd_mag_a_s;
    logic [XLEN-1:0]    opnd_mag_b_s;
    logic               opnd_neg_q_s;
    logic               opnd_neg_r_s;

    logic               start_s;
    logic               step_s;
    logic               load_s;
    logic [XLEN:0]      sum_s;
    logic [2*XLEN-1:0]  acc_step_s;
    logic [2*XLEN-1:0]  prod_s;
    logic [XLEN:0]      trial_s;
    logic [XLEN:0]      diff_s;
    logic               ge_s;
    logic [XLEN:0]      rem_step_s;
    logic [XLEN-1:0]    quo_step_s;
    logic [XLEN-1:0]    result_s;

    qerv_mdu_opnd u_opnd (
        .rs1_i   (i_mdu_rs1),
        .rs2_i   (i_mdu_rs2),
        .op_i    (i_mdu_op),
        .mag_a_o (opnd_mag_a_s),
        .mag_b_o (opnd_mag_b_s),
        .neg_q_o (opnd_neg_q_s),
        .neg_r_o (opnd_neg_r_s)
    );

    // Handshake FSM and iteration counter
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ready_d = 1'b0;
        start_s = 1'b0;
        step_s  = 1'b0;
        load_s  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (i_mdu_valid) begin
                    start_s = 1'b1;
                    cnt_d   = {CNT_W{1'b0}};
                    state_d = S_CALC;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CALC: begin
                step_s = 1'b1;
                cnt_d  = cnt_q + 5'd1;
                if (cnt_q == CNT_LAST) begin
                    load_s  = 1'b1;
                    ready_d = 1'b1;
                    state_d = S_DONE;
                end else begin
                    state_d = S_CALC;
                end
            end
            S_DONE: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (i_mdu_valid) begin
                    state_d = S_WAIT;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // One radix-2 step of both datapaths; the finishing step feeds the result mux
    always_comb begin
        sum_s      = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, (acc_q[0] ? mag_a_q : {XLEN{1'b0}})};
        acc_step_s = {sum_s, acc_q[XLEN-1:1]};
        prod_s     = cond_neg64(neg_quo_q, acc_step_s);

        // A set bit 32 in the partial remainder already exceeds any 32-bit divisor
        trial_s = {rem_q[XLEN-1:0], quo_q[XLEN-1]};
        ge_s    = rem_q[XLEN] | (trial_s >= {1'b0, mag_b_q});
        diff_s  = trial_s - {1'b0, mag_b_q};
        if (ge_s) begin
            rem_step_s = diff_s;
            quo_step_s = {quo_q[XLEN-2:0], 1'b1};
        end else begin
            rem_step_s = trial_s;
            quo_step_s = {quo_q[XLEN-2:0], 1'b0};
        end

        case (op_q)
            F3_MUL:                      result_s = prod_s[XLEN-1:0];
            F3_MULH, F3_MULHSU, F3_MULHU: result_s = prod_s[2*XLEN-1:XLEN];
            F3_DIV, F3_DIVU:             result_s = cond_neg(neg_quo_q, quo_step_s);
            F3_REM, F3_REMU:             result_s = cond_neg(neg_rem_q, rem_step_s[XLEN-1:0]);
            default:                     result_s = {XLEN{1'b0}};
        endcase
    end

    // Datapath next-state: capture on start, iterate in CALC, otherwise hold
    always_comb begin
        op_d      = op_q;
        mag_a_d   = mag_a_q;
        mag_b_d   = mag_b_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        acc_d     = acc_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        if (start_s) begin
            op_d      = i_mdu_op;
            mag_a_d   = opnd_mag_a_s;
            mag_b_d   = opnd_mag_b_s;
            neg_quo_d = opnd_neg_q_s;
            neg_rem_d = opnd_neg_r_s;
            acc_d     = {{XLEN{1'b0}}, opnd_mag_b_s};
            rem_d     = {(XLEN+1){1'b0}};
            quo_d     = opnd_mag_a_s;
        end else if (step_s) begin
            acc_d = acc_step_s;
            rem_d = rem_step_s;
            quo_d = quo_step_s;
        end else begin
            acc_d = acc_q;
        end
        if (load_s) begin
            rd_d = result_s;
        end else begin
            rd_d = rd_q;
        end
    end

    // Control registers with synchronous reset
    always_ff @(posedge clk) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ready_q <= ready_d;
        end
    end

    // Result register; reset only under the MINI strategy
    always_ff @(posedge clk) begin
        if (i_rst) begin
            if (RST_RD) begin
                rd_q <= {XLEN{1'b0}};
            end
        end else begin
            rd_q <= rd_d;
        end
    end

    // Datapath registers, always reinitialised on capture so no reset is needed
    always_ff @(posedge clk) begin
        cnt_q     <= cnt_d;
        op_q      <= op_d;
        mag_a_q   <= mag_a_d;
        mag_b_q   <= mag_b_d;
        neg_quo_q <= neg_quo_d;
        neg_rem_q <= neg_rem_d;
        acc_q     <= acc_d;
        rem_q     <= rem_d;
        quo_q     <= quo_d;
    end

    assign o_mdu_rd    = rd_q;
    assign o_mdu_ready = ready_q;

endmodule
